fifo_wr_rd_ctrl: RTL
====================

Name: fifo_wr_rd_ctrl

Overview:
Sequencer for the ip_fifo FIFO IP: runs write/read passes against the FIFO.
- Each pass waits for the FIFO flags to settle, then fills the FIFO with an incrementing pattern until almost-full/full.
- It then settles again and drains the FIFO until almost-empty/empty, checking every read word against the expected pattern.
- Sits between the FIFO instance and the top level. Provides pass/error counters for status LEDs or debug.

Parameters:
DATA_W, 8, FIFO data width in bits
SETTLE_CYC, 10, idle cycles before each write/read phase (covers FIFO flag synchronisation latency); legal 1..1023
CNT_W, 16, width of pass_cnt and err_cnt

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to run one pass; ignored while busy=1
fifo_full  input  1  FIFO full flag
fifo_almost_full  input  1  FIFO almost-full flag (one free slot left)
fifo_empty  input  1  FIFO empty flag
fifo_almost_empty  input  1  FIFO almost-empty flag (one word left)
fifo_dout  input  DATA_W  FIFO read data, valid one cycle after an accepted read
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  DATA_W  FIFO write data
fifo_rd_en  output  1  FIFO read enable
busy  output  1  high while a pass is in progress
done  output  1  one-cycle pulse at end of each pass
pass_cnt  output  CNT_W  completed passes, saturating
err_cnt  output  CNT_W  read-data mismatches, saturating

Behaviour:
Interface decision: one clock; reset is synchronous and active-high.

Reset values:
- All outputs 0; state=IDLE; write pattern counter wr_dat=0; expected-read counter rd_exp=0; settle counter=0.
- Reset asserted mid-pass aborts immediately: the first edge with sys_rst=1 returns to IDLE.
- fifo_wr_en and fifo_rd_en are low from that edge on. No partial counter updates occur on that edge.

States: IDLE -> WR_SETTLE -> WRITE -> RD_SETTLE -> READ -> DONE -> IDLE.
- IDLE: busy=0. start=1 -> WR_SETTLE, settle counter cleared.
- WR_SETTLE / RD_SETTLE: count SETTLE_CYC cycles. Leave on the cycle the counter reaches SETTLE_CYC-1, so the phase lasts exactly SETTLE_CYC cycles.
- WRITE:
  - fifo_wr_en = (state==WRITE) & ~fifo_full, combinational.
  - fifo_din = wr_dat, registered.
  - Accepted write (fifo_wr_en=1): wr_dat <= wr_dat+1, wrapping mod 2^DATA_W.
  - Exit to RD_SETTLE after an accepted write with fifo_almost_full=1, or on any WRITE cycle with fifo_full=1 (no write that cycle).
- READ:
  - fifo_rd_en = (state==READ) & ~fifo_empty, combinational.
  - Exit to DONE after an accepted read with fifo_almost_empty=1, or on any READ cycle with fifo_empty=1.
- Read-check pipeline:
  - rd_vld_d <= fifo_rd_en.
  - When rd_vld_d=1: compare fifo_dout with rd_exp, then rd_exp <= rd_exp+1 (wrapping).
  - The compare for the final read completes during DONE.
- DONE: done=1 for exactly one cycle; pass_cnt increments, saturating at all-ones; next state IDLE.
- busy=1 in every state except IDLE, including DONE.
- wr_dat and rd_exp are not cleared between passes; they clear only on reset. Pattern continuity across passes is therefore required.
- start asserted while busy is ignored and not queued. start in the same cycle as sys_rst is ignored.
- FIFO already full on entering WRITE: zero writes, exit next cycle. FIFO already empty on entering READ: zero reads, DONE next cycle.

Optional Feature:
Macro FIFO_CHECK_EN.
- Defined: read-check pipeline present; each mismatch increments err_cnt, saturating.
- Undefined: compare logic and rd_exp removed; err_cnt constant 0. All other behaviour and timing are identical.

Test Plan:
1. Reset behaviour: drive sys_rst=1 for 5 cycles, then release -> all outputs 0, busy=0, no wr_en/rd_en pulses for 20 idle cycles.
2. Normal pass: FIFO model depth 16, SETTLE_CYC=4, pulse start ->
   - busy rises next cycle; 4 idle cycles.
   - 16 writes with data 0x00..0x0F; 4 idle cycles.
   - 16 reads; done pulse; pass_cnt=1, err_cnt=0.
3. Back-to-back passes: run two passes -> second pass writes and reads 0x10..0x1F; pass_cnt=2, err_cnt=0. Run 16 passes total at DATA_W=8 -> wr_dat wraps 0xFF->0x00 with err_cnt=0.
4. Data corruption (FIFO_CHECK_EN defined): FIFO model flips bit 0 of the 3rd read word -> err_cnt=1 after done. Same stimulus without the macro -> err_cnt=0.
5. Backpressure and edge cases:
   - FIFO model holds fifo_full=1 on WRITE entry -> zero writes, RD_SETTLE entered after 1 cycle.
   - fifo_empty=1 on READ entry -> done without any rd_en.
   - start pulsed while busy -> no extra pass; pass_cnt increments only once.
6. Reset mid-pass: assert sys_rst during WRITE after 5 writes -> wr_en low from the next edge; state IDLE; wr_dat=0; pass_cnt=0. A new start afterwards writes from 0x00 again.

Source files
------------

// File: rtl/fifo_wr_rd_ctrl.sv
// Write/read pass sequencer for the ip_fifo IP: fills the FIFO with an incrementing pattern, then drains it.
// Define FIFO_CHECK_EN to check each read word against the pattern and count mismatches in err_cnt.
module fifo_wr_rd_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SETTLE_CYC = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              fifo_full,
    input  logic              fifo_almost_full,
    input  logic              fifo_empty,
    input  logic              fifo_almost_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_rd_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned        SET_W    = 10;
    localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETTLE,
        WRITE,
        RD_SETTLE,
        READ,
        DONE
    } state_t;

    state_t             state;
    logic [SET_W-1:0]   set_cnt;
    logic [DATA_W-1:0]  wr_dat;

    // Enables follow the FIFO flags in the same cycle so a full/empty FIFO is never over/under-run.
    assign fifo_wr_en = (state == WRITE) && !fifo_full;
    assign fifo_rd_en = (state == READ) && !fifo_empty;
    assign fifo_din   = wr_dat;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            set_cnt  <= '0;
            wr_dat   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WR_SETTLE;
                        set_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                WR_SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        state   <= WRITE;
                        set_cnt <= '0;
                    end else begin
                        set_cnt <= set_cnt + SET_W'(1);
                    end
                end
                WRITE: begin
                    if (fifo_full) begin
                        state <= RD_SETTLE;
                    end else begin
                        wr_dat <= wr_dat + DATA_W'(1);
                        if (fifo_almost_full) begin
                            state <= RD_SETTLE;
                        end
                    end
                end
                RD_SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        state   <= READ;
                        set_cnt <= '0;
                    end else begin
                        set_cnt <= set_cnt + SET_W'(1);
                    end
                end
                READ: begin
                    // Almost-empty with a read accepted drains the last word; empty means nothing left.
                    if (fifo_empty || fifo_almost_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (pass_cnt != '1) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_CHECK_EN
    logic              rd_vld_d;
    logic [DATA_W-1:0] rd_exp;

    // Read data lands one cycle after the enable; the last compare resolves during DONE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_vld_d <= 1'b0;
            rd_exp   <= '0;
            err_cnt  <= '0;
        end else begin
            rd_vld_d <= fifo_rd_en;
            if (rd_vld_d) begin
                rd_exp <= rd_exp + DATA_W'(1);
                if ((fifo_dout != rd_exp) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_dout;

    assign unused_dout = ^fifo_dout;
    assign err_cnt     = '0;
`endif

endmodule
